gpr_file_sb: RTL and testbench

// - Parametrised general-purpose register file for the next core: 2 combinational read ports, 1 write port.
// - Optional write-to-read bypass and optional hardwired-zero R0.
// - Per-register scoreboard (busy bits) so the decode stage can detect RAW and WAW hazards on in-flight results.
// - Sits between decode (read/issue) and writeback (write/clear).

---
 rtl/gpr_pkg.sv | 11 +
 rtl/gpr_scoreboard.sv | 68 ++++++
 rtl/gpr_file_sb.sv | 75 +++++++
 tb/tb_gpr_file_sb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared defaults and types for the general-purpose register file with scoreboard.
package gpr_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 3;
    localparam int unsigned NumRegs  = 1 << DefAddrW;

    typedef logic [DefAddrW-1:0] reg_addr_t;
    typedef logic [DefDataW-1:0] reg_data_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on collision.
// Also provides busy lookups for both read ports and the registered WAW pulse.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0,
    localparam int unsigned NRegs  = 1 << ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              sb_set_en_i,
    input  logic [ADDR_W-1:0] sb_set_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_1_i,
    input  logic [ADDR_W-1:0] rd_addr_2_i,
    output logic              rd_busy_1_o,
    output logic              rd_busy_2_o,
    output logic              waw_err_o,
    output logic [NRegs-1:0]  busy_vec_o
);

    logic [NRegs-1:0] busy_q, busy_d;
    logic             waw_q, waw_d;
    logic             set_eff;

    // R0 can never hold a pending producer when it is hardwired to zero.
    assign set_eff = sb_set_en_i && !(ZERO_R0 && (sb_set_addr_i == '0));

    always_comb begin
        busy_d = busy_q;
        if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
        if (set_eff) busy_d[sb_set_addr_i] = 1'b1;
    end

    assign waw_d = set_eff && busy_q[sb_set_addr_i]
                   && !(wr_en_i && (wr_addr_i == sb_set_addr_i));

    // A same-cycle writeback hides the busy bit because its data reaches the reader via bypass.
    always_comb begin
        rd_busy_1_o = busy_q[rd_addr_1_i];
        if (BYPASS && wr_en_i && (wr_addr_i == rd_addr_1_i)
            && !(set_eff && (sb_set_addr_i == rd_addr_1_i))) begin
            rd_busy_1_o = 1'b0;
        end
        rd_busy_2_o = busy_q[rd_addr_2_i];
        if (BYPASS && wr_en_i && (wr_addr_i == rd_addr_2_i)
            && !(set_eff && (sb_set_addr_i == rd_addr_2_i))) begin
            rd_busy_2_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            waw_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            waw_q  <= waw_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign waw_err_o  = waw_q;

endmodule

// File: rtl/gpr_file_sb.sv
// Register file: two combinational read ports, one write port, optional bypass and zero R0,
// with a scoreboard for RAW/WAW hazard detection between decode and writeback.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0,
    localparam int unsigned NRegs  = 1 << ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_1_i,
    output logic [DATA_W-1:0] rd_data_1_o,
    output logic              rd_busy_1_o,
    input  logic [ADDR_W-1:0] rd_addr_2_i,
    output logic [DATA_W-1:0] rd_data_2_o,
    output logic              rd_busy_2_o,
    input  logic              sb_set_en_i,
    input  logic [ADDR_W-1:0] sb_set_addr_i,
    output logic              hazard_o,
    output logic              waw_err_o,
    output logic [NRegs-1:0]  busy_vec_o
);

    logic [DATA_W-1:0] regs_q [NRegs];
    logic              wr_fire;

    assign wr_fire = wr_en_i && !(ZERO_R0 && (wr_addr_i == '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NRegs; i++) regs_q[i] <= '0;
        end else if (wr_fire) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reset gating keeps a bypassed wr_data from leaking out while rst_ni is low.
    always_comb begin
        rd_data_1_o = regs_q[rd_addr_1_i];
        if (BYPASS && wr_fire && (wr_addr_i == rd_addr_1_i)) rd_data_1_o = wr_data_i;
        if (!rst_ni || (ZERO_R0 && (rd_addr_1_i == '0))) rd_data_1_o = '0;

        rd_data_2_o = regs_q[rd_addr_2_i];
        if (BYPASS && wr_fire && (wr_addr_i == rd_addr_2_i)) rd_data_2_o = wr_data_i;
        if (!rst_ni || (ZERO_R0 && (rd_addr_2_i == '0))) rd_data_2_o = '0;
    end

    gpr_scoreboard #(
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .sb_set_en_i   (sb_set_en_i),
        .sb_set_addr_i (sb_set_addr_i),
        .rd_addr_1_i   (rd_addr_1_i),
        .rd_addr_2_i   (rd_addr_2_i),
        .rd_busy_1_o   (rd_busy_1_o),
        .rd_busy_2_o   (rd_busy_2_o),
        .waw_err_o     (waw_err_o),
        .busy_vec_o    (busy_vec_o)
    );

    assign hazard_o = rd_busy_1_o | rd_busy_2_o;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench: three builds (bypass, no bypass, zero-R0 16x16) driven in lockstep and checked
// against a per-build array model.
module tb_gpr_file_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        sb_set = 1'b0;
    logic [3:0]  wa = '0, ra1 = '0, ra2 = '0, sa = '0;
    logic [15:0] wd = '0;

    logic [7:0]  rd1_a, rd2_a, rd1_b, rd2_b, bv_a, bv_b;
    logic [15:0] rd1_c, rd2_c, bv_c;
    logic [2:0]  bz1, bz2, hz, waw;

    logic [15:0] mem [3][16];
    logic [15:0] busy_m [3];
    logic        waw_m [3];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    gpr_file_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wa[2:0]), .wr_data_i(wd[7:0]),
        .rd_addr_1_i(ra1[2:0]), .rd_data_1_o(rd1_a), .rd_busy_1_o(bz1[0]),
        .rd_addr_2_i(ra2[2:0]), .rd_data_2_o(rd2_a), .rd_busy_2_o(bz2[0]),
        .sb_set_en_i(sb_set), .sb_set_addr_i(sa[2:0]), .hazard_o(hz[0]), .waw_err_o(waw[0]),
        .busy_vec_o(bv_a)
    );

    gpr_file_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wa[2:0]), .wr_data_i(wd[7:0]),
        .rd_addr_1_i(ra1[2:0]), .rd_data_1_o(rd1_b), .rd_busy_1_o(bz1[1]),
        .rd_addr_2_i(ra2[2:0]), .rd_data_2_o(rd2_b), .rd_busy_2_o(bz2[1]),
        .sb_set_en_i(sb_set), .sb_set_addr_i(sa[2:0]), .hazard_o(hz[1]), .waw_err_o(waw[1]),
        .busy_vec_o(bv_b)
    );

    gpr_file_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wa), .wr_data_i(wd),
        .rd_addr_1_i(ra1), .rd_data_1_o(rd1_c), .rd_busy_1_o(bz1[2]),
        .rd_addr_2_i(ra2), .rd_data_2_o(rd2_c), .rd_busy_2_o(bz2[2]),
        .sb_set_en_i(sb_set), .sb_set_addr_i(sa), .hazard_o(hz[2]), .waw_err_o(waw[2]),
        .busy_vec_o(bv_c)
    );

    // Build configuration of each instance.
    function automatic logic [3:0] am(int k);
        return (k == 2) ? 4'hF : 4'h7;
    endfunction
    function automatic logic [15:0] dm(int k);
        return (k == 2) ? 16'hFFFF : 16'h00FF;
    endfunction
    function automatic bit byp(int k);
        return k != 1;
    endfunction
    function automatic bit zr(int k);
        return k == 2;
    endfunction

    function automatic logic [15:0] get_rd(int k, int p);
        case (k)
            0:       return (p == 1) ? {8'h00, rd1_a} : {8'h00, rd2_a};
            1:       return (p == 1) ? {8'h00, rd1_b} : {8'h00, rd2_b};
            default: return (p == 1) ? rd1_c : rd2_c;
        endcase
    endfunction
    function automatic logic [15:0] get_bv(int k);
        case (k)
            0:       return {8'h00, bv_a};
            1:       return {8'h00, bv_b};
            default: return bv_c;
        endcase
    endfunction

    // Expected read value from the stored array plus the current write-port inputs.
    function automatic logic [15:0] exp_rd(int k, logic [3:0] a);
        logic [3:0] aa, aw;
        aa = a & am(k);
        aw = wa & am(k);
        if (!rst_n) return 16'h0;
        if (zr(k) && aa == 4'h0) return 16'h0;
        if (byp(k) && wr_en && aw == aa) return wd & dm(k);
        return mem[k][aa];
    endfunction

    function automatic logic exp_busy(int k, logic [3:0] a);
        logic [3:0] aa, aw, as;
        aa = a & am(k);
        aw = wa & am(k);
        as = sa & am(k);
        if (!rst_n) return 1'b0;
        if (byp(k) && wr_en && aw == aa && !(sb_set && as == aa)) return 1'b0;
        return busy_m[k][aa];
    endfunction

    task automatic chk(input string tag, input int k, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s inst%0d observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic check_comb();
        for (int k = 0; k < 3; k++) begin
            chk("rd_data_1", k, get_rd(k, 1), exp_rd(k, ra1));
            chk("rd_data_2", k, get_rd(k, 2), exp_rd(k, ra2));
            chk("rd_busy_1", k, {15'h0, bz1[k]}, {15'h0, exp_busy(k, ra1)});
            chk("rd_busy_2", k, {15'h0, bz2[k]}, {15'h0, exp_busy(k, ra2)});
            chk("hazard", k, {15'h0, hz[k]}, {15'h0, exp_busy(k, ra1) | exp_busy(k, ra2)});
        end
    endtask

    task automatic check_reg();
        for (int k = 0; k < 3; k++) begin
            chk("busy_vec", k, get_bv(k), busy_m[k]);
            chk("waw_err", k, {15'h0, waw[k]}, {15'h0, waw_m[k]});
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) mem[k][i] = '0;
            busy_m[k] = '0;
            waw_m[k]  = 1'b0;
        end
    endtask

    // Drive one cycle, check combinational outputs before the edge, registered ones after.
    task automatic step(input logic we, input logic [3:0] w_a, input logic [15:0] w_d,
                        input logic [3:0] r1, input logic [3:0] r2,
                        input logic se, input logic [3:0] s_a);
        logic [3:0] aw, as;
        wr_en = we; wa = w_a; wd = w_d; ra1 = r1; ra2 = r2; sb_set = se; sa = s_a;
        #1;
        check_comb();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            aw = wa & am(k);
            as = sa & am(k);
            waw_m[k] = 1'b0;
            if (sb_set && !(zr(k) && as == 4'h0)) begin
                waw_m[k] = busy_m[k][as] && !(wr_en && aw == as);
            end
            if (wr_en) busy_m[k][aw] = 1'b0;
            if (sb_set && !(zr(k) && as == 4'h0)) busy_m[k][as] = 1'b1;
            if (wr_en && !(zr(k) && aw == 4'h0)) mem[k][aw] = wd & dm(k);
        end
        #1;
        check_reg();
    endtask

    // Asynchronous reset mid-cycle while a bypassing write and a set are being presented.
    task automatic do_reset();
        wr_en = 1'b1; wa = 4'd5; wd = 16'h1234; ra1 = 4'd5; ra2 = 4'd3; sb_set = 1'b1; sa = 4'd5;
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_comb();
        check_reg();
        @(posedge clk);
        #1;
        check_reg();
        wr_en = 1'b0; sb_set = 1'b0;
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        clear_model();
        #1;
        check_comb();
        check_reg();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write R3, then read it on both ports; R4 stays 0.
        step(1'b1, 4'd3, 16'hBEA5, 4'd0, 4'd0, 1'b0, 4'd0);
        step(1'b0, 4'd0, 16'h0000, 4'd3, 4'd3, 1'b0, 4'd0);
        chk("t2_r3_p1", 0, {8'h00, rd1_a}, 16'h00A5);
        chk("t2_r3_p2", 2, rd2_c, 16'hBEA5);
        step(1'b0, 4'd0, 16'h0000, 4'd4, 4'd3, 1'b0, 4'd0);
        chk("t2_r4", 0, {8'h00, rd1_a}, 16'h0000);

        // Same-cycle write R5 observed through the bypass (or not).
        step(1'b1, 4'd5, 16'h003C, 4'd5, 4'd5, 1'b0, 4'd0);

        // Scoreboard set, read-busy, clear, then set+clear together.
        step(1'b0, 4'd0, 16'h0000, 4'd2, 4'd1, 1'b1, 4'd2);
        chk("t4_busy2", 0, {8'h00, bv_a}, 16'h0004);
        chk("t4_rdbusy", 0, {15'h0, bz1[0]}, 16'h0001);
        chk("t4_hazard", 0, {15'h0, hz[0]}, 16'h0001);
        step(1'b1, 4'd2, 16'h0011, 4'd2, 4'd2, 1'b0, 4'd0);
        chk("t4_clear", 0, {8'h00, bv_a}, 16'h0000);
        step(1'b1, 4'd2, 16'h0022, 4'd2, 4'd0, 1'b1, 4'd2);
        chk("t4_setwins", 0, {8'h00, bv_a}, 16'h0004);

        // WAW on R6: two consecutive sets pulse once, then set+clear suppresses.
        step(1'b0, 4'd0, 16'h0000, 4'd6, 4'd0, 1'b1, 4'd6);
        chk("t5_nowaw", 0, {15'h0, waw[0]}, 16'h0000);
        step(1'b0, 4'd0, 16'h0000, 4'd6, 4'd0, 1'b1, 4'd6);
        chk("t5_waw", 0, {15'h0, waw[0]}, 16'h0001);
        step(1'b1, 4'd6, 16'h0066, 4'd6, 4'd0, 1'b1, 4'd6);
        chk("t5_suppress", 0, {15'h0, waw[0]}, 16'h0000);
        step(1'b0, 4'd0, 16'h0000, 4'd6, 4'd0, 1'b0, 4'd0);
        chk("t5_oneshot", 0, {15'h0, waw[0]}, 16'h0000);

        // Writes and sets to R0 on the zero-R0 build.
        step(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b1, 4'd0);
        step(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b1, 4'd0);
        chk("t6_r0", 2, rd1_c, 16'h0000);
        chk("t6_busy0", 2, {15'h0, bv_c[0]}, 16'h0000);

        // Reset mid-run after writes.
        do_reset();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom), rnd_addr(), rnd_addr(),
                     1'($urandom_range(0, 1)), rnd_addr());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
